// File: rtl/mem_if_pkg.sv
// Shared types for the memory access controller:
// FSM states, arbitration modes and grant encoding.
package mem_if_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    DONE
  } state_t;

  typedef enum logic {
    GRANT_IF,
    GRANT_D
  } grant_t;

  localparam int ARB_DATA_PRIO   = 0;
  localparam int ARB_ROUND_ROBIN = 1;

endpackage

// File: rtl/mem_word_array.sv
// Single-port word storage with byte-lane writes
// and a registered read port.
module mem_word_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024,
  parameter int IDX_W      = 10
) (
  input  logic                    clk,
  input  logic                    en,
  input  logic                    we,
  input  logic [DATA_WIDTH/8-1:0] be,
  input  logic [IDX_W-1:0]        addr,
  input  logic [DATA_WIDTH-1:0]   wdata,
  output logic [DATA_WIDTH-1:0]   rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < DATA_WIDTH / 8; i++) begin
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_access_controller.sv
// Fetch + data port controller over one shared word array,
// with wait states, arbitration and out-of-range detection.
module mem_access_controller
  import mem_if_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 2,
  parameter int ARB_MODE    = 0
) (
  input  logic                    Clock,
  input  logic                    Reset,
  input  logic                    IF_Req,
  input  logic [ADDR_WIDTH-1:0]   IF_Address,
  output logic [DATA_WIDTH-1:0]   IF_Data_Out,
  output logic                    IF_MFC,
  input  logic                    D_Req,
  input  logic                    D_Read_H_Write_L,
  input  logic [ADDR_WIDTH-1:0]   D_Address,
  input  logic [DATA_WIDTH-1:0]   D_Data_In,
  input  logic [DATA_WIDTH/8-1:0] D_Byte_En,
  output logic [DATA_WIDTH-1:0]   D_Data_Out,
  output logic                    D_MFC,
  output logic                    D_Err
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_WIDTH:0] LIMIT =
    (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [3:0] CNT_INIT =
    4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_t                state;
  grant_t                grant;
  grant_t                last_grant;
  logic [3:0]            cnt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [BE_W-1:0]       be;
  logic                  rd;
  logic [DATA_WIDTH-1:0] if_hold;
  logic [DATA_WIDTH-1:0] d_hold;
  logic [DATA_WIDTH-1:0] rdata;

  grant_t                cur_grant;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [DATA_WIDTH-1:0] cur_wdata;
  logic [BE_W-1:0]       cur_be;
  logic                  cur_rd;
  logic                  pick_d;
  logic                  accept;
  logic                  go_done;
  logic                  oor;

  assign accept  = (state == IDLE) && (IF_Req || D_Req);
  assign go_done = (accept && (WAIT_STATES == 0)) ||
                   (state == WAIT && cnt == 4'd0);

  always_comb begin
    pick_d = D_Req;
    if (ARB_MODE == ARB_ROUND_ROBIN && IF_Req && D_Req)
      pick_d = (last_grant == GRANT_IF);
  end

  // In IDLE the live port inputs drive the access so that
  // zero-wait-state accesses can hit the array on the accept edge.
  always_comb begin
    cur_grant = grant;
    cur_addr  = addr;
    cur_wdata = wdata;
    cur_be    = be;
    cur_rd    = rd;
    if (state == IDLE) begin
      cur_grant = pick_d ? GRANT_D : GRANT_IF;
      cur_addr  = pick_d ? D_Address : IF_Address;
      cur_rd    = pick_d ? D_Read_H_Write_L : 1'b1;
      cur_wdata = D_Data_In;
      cur_be    = D_Byte_En;
    end
  end

  assign oor = {1'b0, cur_addr} >= LIMIT;

  mem_word_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH),
    .IDX_W     (IDX_W)
  ) u_array (
    .clk  (Clock),
    .en   (go_done && !oor && !Reset),
    .we   (!cur_rd),
    .be   (cur_be),
    .addr (cur_addr[IDX_W-1:0]),
    .wdata(cur_wdata),
    .rdata(rdata)
  );

  always_comb begin
    IF_Data_Out = if_hold;
    D_Data_Out  = d_hold;
    if (state == DONE) begin
      if (grant == GRANT_IF)
        IF_Data_Out = oor ? '0 : rdata;
      else if (rd)
        D_Data_Out = oor ? '0 : rdata;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      grant      <= GRANT_IF;
      last_grant <= GRANT_IF;
      addr       <= '0;
      wdata      <= '0;
      be         <= '0;
      rd         <= 1'b1;
      if_hold    <= '0;
      d_hold     <= '0;
      IF_MFC     <= 1'b0;
      D_MFC      <= 1'b0;
      D_Err      <= 1'b0;
    end else begin
      IF_MFC <= go_done && cur_grant == GRANT_IF;
      D_MFC  <= go_done && cur_grant == GRANT_D;
      D_Err  <= go_done && cur_grant == GRANT_D && oor;
      unique case (state)
        IDLE: begin
          if (accept) begin
            grant      <= cur_grant;
            last_grant <= cur_grant;
            addr       <= cur_addr;
            wdata      <= cur_wdata;
            be         <= cur_be;
            rd         <= cur_rd;
            cnt        <= CNT_INIT;
            state      <= (WAIT_STATES == 0) ? DONE : WAIT;
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= DONE;
          else cnt <= cnt - 4'd1;
        end
        DONE: begin
          state   <= IDLE;
          if_hold <= IF_Data_Out;
          d_hold  <= D_Data_Out;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
